fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipelined MIPS core. It holds the program counter, drives the instruction-memory address, and latches the fetched word plus PC+4 into the IF/ID pipeline register consumed by the decode stage. It applies load-use stalls from the hazard unit and branch/jump redirects resolved in ID. It stops fetching cleanly once the PC leaves the loaded program.

## Interface
- PC_RESET, 32'h0000_0000, PC value after reset.
- IMEM_WORDS, 64, number of program words. A word index `pc[31:2] >= IMEM_WORDS` is past the end of the program.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset. **Synchronous, active-low.**
- stall  in  1  hazard-unit hold request for PC and IF/ID.
- redirect  in  1  taken branch or jump resolved in ID.
- redirect_pc  in  32  target for `redirect`.
- imem_rdata  in  32  combinational instruction-memory read data for `imem_addr`.
- imem_addr  out  32  equals `pc_out` (combinational).
- pc_out  out  32  current PC register.
- if_id_instr  out  32  latched instruction; 32'h0 (nop) when invalid.
- if_id_pc4  out  32  latched PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_done  out  1  high while in state END.
- fetch_count  out  32  number of valid instructions latched; saturates at 32'hFFFF_FFFF.

## Operation
Reset (rst_n low at an edge):
- pc_out = PC_RESET.
- if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0, fetch_count = 0.
- State = RUN; fetch_done = 0.
- Reset overrides stall and redirect.

States: RUN and END. The per-edge priority when rst_n is high is redirect > stall > normal.

- **redirect:**
  - pc <= {redirect_pc[31:2], 2'b00}; the low two bits are forced to zero.
  - IF/ID flushes to instr 0, pc4 0, valid 0.
  - The next state is RUN if the target index is below IMEM_WORDS, else END.
  - Applies even when stall=1.
- **stall (no redirect):** pc, IF/ID, state and fetch_count all hold.
- **RUN, normal:**
  - if_id_instr <= imem_rdata, if_id_pc4 <= pc+4, if_id_valid <= 1, fetch_count += 1.
  - pc <= pc+4, with 32-bit wrap-around.
  - If the index of pc+4 is at or above IMEM_WORDS, go to END.
- **END, normal:**
  - pc holds.
  - IF/ID loads a bubble (instr 0, valid 0); fetch_count holds.
  - imem_rdata is ignored.
  - Only a redirect or reset leaves END. This covers a branch still in flight in the pipe.
- fetch_count does not wrap; it stays at the maximum value once reached.

## Timing
- Fetch-to-IF/ID latency is 1 cycle. The word at imem_addr during cycle n appears on if_id_* after edge n.
- Branch penalty is 1 bubble. Redirect at edge n gives pc_out = target and if_id_valid = 0 after edge n; the target instruction is in IF/ID after edge n+1.
- Stall is effective at the same edge and can be held for any number of cycles. Outputs are unchanged for every stalled edge.
- All outputs are registered except imem_addr.

## Test plan
1. **Reset and sequential fetch.** rst_n low 2 edges, then imem returns 0x20100001, 0x20110002, 0x02309020.
   - During reset: pc_out = 0, valid = 0, fetch_count = 0.
   - After 3 edges: pc_out = 0xC, if_id_instr = 0x02309020, if_id_pc4 = 0xC, fetch_count = 3.
2. **Stall.** stall=1 for 3 edges at pc = 0x8.
   - pc_out stays 0x8 and IF/ID and fetch_count are unchanged.
   - After release, fetch resumes with 0x8's word latched.
3. **Redirect, including simultaneous stall.**
   - redirect=1, redirect_pc=0x24 at pc=0x10, with stall=1 in the same cycle: pc_out = 0x24, valid = 0.
   - Next edge: if_id_pc4 = 0x28, valid = 1.
4. **Misaligned target.** redirect_pc = 0x2E -> pc_out = 0x2C.
5. **End of program.** IMEM_WORDS=4, run from 0.
   - After edge 4: fetch_done = 1, pc_out = 0x10 and holds, valid = 0 on every later edge, fetch_count = 4.
   - Then redirect to 0x4: state RUN, and the word at 0x4 is latched one edge later.
6. **Reset mid-operation.** rst_n low for one edge at pc = 0x14 with stall=1 and redirect=1.
   - All outputs return to their reset values, and fetch restarts at 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, honouring stalls, ID-stage redirects and end of program.
module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_done,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  S_RUN      = 1'b0;
    localparam logic [0:0]  S_END      = 1'b1;
    localparam logic [31:0] WORD_LIMIT = 32'(IMEM_WORDS);
    localparam logic [31:0] COUNT_MAX  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    logic [31:0] pc;
    logic [0:0]  state;
    logic [31:0] pc_seq;
    logic [31:0] target;
    logic        seq_past_end;
    logic        target_past_end;

    // Past-end tests compare the word index (pc[31:2]) against the program size.
    always_comb begin
        pc_seq          = pc + 32'd4;
        target          = {redirect_pc[31:2], 2'b00};
        seq_past_end    = ({2'b00, pc_seq[31:2]} >= WORD_LIMIT);
        target_past_end = ({2'b00, target[31:2]} >= WORD_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= PC_RESET;
            state       <= S_RUN;
            if_id_instr <= NOP;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            fetch_count <= 32'd0;
        end else if (redirect) begin
            pc          <= target;
            state       <= target_past_end ? S_END : S_RUN;
            if_id_instr <= NOP;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if (state == S_RUN) begin
                pc          <= pc_seq;
                if_id_instr <= imem_rdata;
                if_id_pc4   <= pc_seq;
                if_id_valid <= 1'b1;
                if (fetch_count != COUNT_MAX) begin
                    fetch_count <= fetch_count + 32'd1;
                end
                if (seq_past_end) begin
                    state <= S_END;
                end
            end else begin
                // Parked past the program: keep feeding bubbles until ID redirects us.
                if_id_instr <= NOP;
                if_id_pc4   <= 32'd0;
                if_id_valid <= 1'b0;
            end
        end
    end

    assign pc_out     = pc;
    assign imem_addr  = pc;
    assign fetch_done = (state == S_END);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a 64-word and a 4-word instance run side by side
// against a behavioural model, through directed scenarios and then random traffic.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] rdata [2];
    logic [31:0] o_addr [2];
    logic [31:0] o_pc [2];
    logic [31:0] o_instr [2];
    logic [31:0] o_pc4 [2];
    logic        o_valid [2];
    logic        o_done [2];
    logic [31:0] o_count [2];

    logic [31:0] mem [0:63];

    // Reference model state, one slot per instance.
    int          words [2] = '{64, 4};
    logic [31:0] m_pc [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc4 [2];
    logic        m_pc4_known [2];
    logic        m_valid [2];
    logic        m_done [2];
    logic [31:0] m_count [2];

    int checks = 0;
    int passed = 0;
    int failed = 0;

    fetch_stage #(.IMEM_WORDS(64)) u_big (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_rdata(rdata[0]), .imem_addr(o_addr[0]),
        .pc_out(o_pc[0]), .if_id_instr(o_instr[0]), .if_id_pc4(o_pc4[0]),
        .if_id_valid(o_valid[0]), .fetch_done(o_done[0]), .fetch_count(o_count[0])
    );

    fetch_stage #(.IMEM_WORDS(4)) u_small (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_rdata(rdata[1]), .imem_addr(o_addr[1]),
        .pc_out(o_pc[1]), .if_id_instr(o_instr[1]), .if_id_pc4(o_pc4[1]),
        .if_id_valid(o_valid[1]), .fetch_done(o_done[1]), .fetch_count(o_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a[31:8] == 24'd0) return mem[a[7:2]];
        return 32'hBAD0_BAD0;
    endfunction

    always_comb begin
        rdata[0] = imem_word(o_addr[0]);
        rdata[1] = imem_word(o_addr[1]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pc[k] = 32'h0;
                m_instr[k] = 32'h0;
                m_pc4[k] = 32'h0;
                m_pc4_known[k] = 1'b1;
                m_valid[k] = 1'b0;
                m_done[k] = 1'b0;
                m_count[k] = 32'h0;
            end else if (redirect) begin
                m_pc[k] = redirect_pc & ~32'd3;
                m_instr[k] = 32'h0;
                m_pc4[k] = 32'h0;
                m_pc4_known[k] = 1'b1;
                m_valid[k] = 1'b0;
                m_done[k] = (m_pc[k] / 4) >= 32'(words[k]);
            end else if (stall) begin
                // everything holds
            end else if (!m_done[k]) begin
                m_instr[k] = imem_word(m_pc[k]);
                m_pc[k] = m_pc[k] + 32'd4;
                m_pc4[k] = m_pc[k];
                m_pc4_known[k] = 1'b1;
                m_valid[k] = 1'b1;
                if (m_count[k] != 32'hFFFF_FFFF) m_count[k] = m_count[k] + 32'd1;
                m_done[k] = (m_pc[k] / 4) >= 32'(words[k]);
            end else begin
                m_instr[k] = 32'h0;
                m_valid[k] = 1'b0;
                m_pc4_known[k] = 1'b0;
            end
        end
    endtask

    task automatic check_output();
        for (int k = 0; k < 2; k++) begin
            string n;
            n = (k == 0) ? "big" : "small";
            chk({n, ".pc_out"}, o_pc[k], m_pc[k]);
            chk({n, ".imem_addr"}, o_addr[k], m_pc[k]);
            chk({n, ".instr"}, o_instr[k], m_instr[k]);
            if (m_pc4_known[k]) chk({n, ".pc4"}, o_pc4[k], m_pc4[k]);
            chk({n, ".valid"}, 32'(o_valid[k]), 32'(m_valid[k]));
            chk({n, ".done"}, 32'(o_done[k]), 32'(m_done[k]));
            chk({n, ".count"}, o_count[k], m_count[k]);
        end
    endtask

    // Drive one edge's worth of inputs, step the model, and compare just after the edge.
    task automatic apply_stimulus(input logic r, input logic s, input logic rd,
                                  input logic [31:0] tgt);
        rst_n = r;
        stall = s;
        redirect = rd;
        redirect_pc = tgt;
        model_step();
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2010_0001;
        mem[1] = 32'h2011_0002;
        mem[2] = 32'h0230_9020;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);

        // Reset and sequential fetch
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h40);
        chk("reset.pc", o_pc[0], 32'h0);
        chk("reset.valid", 32'(o_valid[0]), 32'h0);
        chk("reset.count", o_count[0], 32'h0);
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        chk("seq.pc", o_pc[0], 32'hC);
        chk("seq.instr", o_instr[0], 32'h0230_9020);
        chk("seq.pc4", o_pc4[0], 32'hC);
        chk("seq.count", o_count[0], 32'd3);

        // Stall at pc 0x8, then resume
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h8);
        repeat (3) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
            chk("stall.pc", o_pc[0], 32'h8);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        chk("resume.instr", o_instr[0], 32'h0230_9020);
        chk("resume.pc4", o_pc4[0], 32'hC);

        // Redirect with simultaneous stall at pc 0x10
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        chk("pre_redirect.pc", o_pc[0], 32'h10);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h24);
        chk("redirect.pc", o_pc[0], 32'h24);
        chk("redirect.valid", 32'(o_valid[0]), 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        chk("target.pc4", o_pc4[0], 32'h28);
        chk("target.valid", 32'(o_valid[0]), 32'h1);

        // Misaligned redirect target
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h2E);
        chk("misaligned.pc", o_pc[0], 32'h2C);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // End of program on the 4-word instance
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        chk("end.done", 32'(o_done[1]), 32'h1);
        chk("end.pc", o_pc[1], 32'h10);
        chk("end.count", o_count[1], 32'd4);
        repeat (3) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
            chk("end.hold_pc", o_pc[1], 32'h10);
            chk("end.bubble", 32'(o_valid[1]), 32'h0);
        end
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h4);
        chk("end.leave", 32'(o_done[1]), 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        chk("end.refetch", o_instr[1], 32'h2011_0002);

        // Reset mid-operation overrides stall and redirect
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h14);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h30);
        chk("midreset.pc", o_pc[0], 32'h0);
        chk("midreset.count", o_count[0], 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        chk("restart.instr", o_instr[0], 32'h2010_0001);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic s;
            logic rd;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 10);
            t  = 32'($urandom_range(0, 32'h120));
            apply_stimulus(r, s, rd, t);
        end

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
